// File: rtl/dac_i2s_tx.sv
// rtl/dac_i2s_tx.sv - I2S transmitter for a stereo DAC with a one-pair holding register.
// Defining DAC_I2S_UNDERRUN_CNT_EN adds the saturating underrun_cnt output.
module dac_i2s_tx #(
  parameter int BCK_DIV = 8,
  parameter int WORD_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [WORD_W-1:0] in_left,
  input  logic [WORD_W-1:0] in_right,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dac_bck,
  output logic              dac_lrck,
  output logic              dac_adata,
  output logic              underrun,
  output logic              frame_start
`ifdef DAC_I2S_UNDERRUN_CNT_EN
  ,
  output logic [15:0]       underrun_cnt
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] DIV_LAST = 8'(BCK_DIV - 1);
  localparam logic [5:0] LAST_DATA_SLOT = 6'(WORD_W);

  state_t            state;
  logic [7:0]        div_cnt;
  logic [5:0]        bit_cnt;
  logic              hold_full;
  logic [WORD_W-1:0] hold_l;
  logic [WORD_W-1:0] hold_r;
  logic [WORD_W-1:0] shift_l;
  logic [WORD_W-1:0] shift_r;

  logic       div_hit;
  logic       bck_fall;
  logic       frame_load;
  logic       capture;
  logic       data_slot;
  logic [5:0] next_bit;

  assign in_ready   = ~hold_full;
  assign capture    = in_valid && ~hold_full;
  assign div_hit    = (div_cnt == DIV_LAST);
  assign bck_fall   = (state == RUN) && div_hit && dac_bck;
  assign frame_load = bck_fall && (bit_cnt == 6'd63);
  assign next_bit   = bit_cnt + 6'd1;
  // Slot 0 of each half is the I2S one-BCK delay; data occupies slots 1..WORD_W.
  assign data_slot  = (next_bit[4:0] != 5'd0) && ({1'b0, next_bit[4:0]} <= LAST_DATA_SLOT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= 8'd0;
      bit_cnt     <= 6'd63;
      dac_bck     <= 1'b0;
      dac_lrck    <= 1'b0;
      dac_adata   <= 1'b0;
      hold_full   <= 1'b0;
      hold_l      <= '0;
      hold_r      <= '0;
      shift_l     <= '0;
      shift_r     <= '0;
      underrun    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      underrun    <= 1'b0;
      frame_start <= 1'b0;

      // Capture is only possible with the holding register empty, so it never
      // collides with the frame-load clear below.
      if (capture) begin
        hold_l    <= in_left;
        hold_r    <= in_right;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          div_cnt   <= 8'd0;
          bit_cnt   <= 6'd63;
          dac_bck   <= 1'b0;
          dac_lrck  <= 1'b0;
          dac_adata <= 1'b0;
          if (enable) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (div_hit) begin
            div_cnt <= 8'd0;
            dac_bck <= ~dac_bck;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end

          if (frame_load && !enable) begin
            // Stop on the frame boundary; the holding register survives for the next run.
            state     <= IDLE;
            div_cnt   <= 8'd0;
            bit_cnt   <= 6'd63;
            dac_bck   <= 1'b0;
            dac_lrck  <= 1'b0;
            dac_adata <= 1'b0;
            shift_l   <= '0;
            shift_r   <= '0;
          end else if (frame_load) begin
            bit_cnt     <= 6'd0;
            dac_lrck    <= 1'b0;
            dac_adata   <= 1'b0;
            frame_start <= 1'b1;
            if (hold_full) begin
              shift_l   <= hold_l;
              shift_r   <= hold_r;
              hold_full <= 1'b0;
            end else begin
              shift_l  <= '0;
              shift_r  <= '0;
              underrun <= 1'b1;
            end
          end else if (bck_fall) begin
            bit_cnt  <= next_bit;
            dac_lrck <= next_bit[5];
            if (!data_slot) begin
              dac_adata <= 1'b0;
            end else if (next_bit[5]) begin
              dac_adata <= shift_r[WORD_W-1];
              shift_r   <= {shift_r[WORD_W-2:0], 1'b0};
            end else begin
              dac_adata <= shift_l[WORD_W-1];
              shift_l   <= {shift_l[WORD_W-2:0], 1'b0};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef DAC_I2S_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= 16'd0;
    end else if (underrun && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_i2s_tx.sv
// tb/tb_dac_i2s_tx.sv - directed and randomized bench for dac_i2s_tx against a frame-level model.
module tb_dac_i2s_tx;

  localparam int BCK_DIV = 2;
  localparam int WORD_W  = 24;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [WORD_W-1:0] in_left;
  logic [WORD_W-1:0] in_right;
  logic              in_valid;
  logic              in_ready;
  logic              dac_bck;
  logic              dac_lrck;
  logic              dac_adata;
  logic              underrun;
  logic              frame_start;
`ifdef DAC_I2S_UNDERRUN_CNT_EN
  logic [15:0]       underrun_cnt;
`endif

  dac_i2s_tx #(.BCK_DIV(BCK_DIV), .WORD_W(WORD_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .in_left(in_left),
    .in_right(in_right),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dac_bck(dac_bck),
    .dac_lrck(dac_lrck),
    .dac_adata(dac_adata),
    .underrun(underrun),
    .frame_start(frame_start)
`ifdef DAC_I2S_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_fall = 0;
  int          slot = 0;
  int          exp_urun = 0;
  bit          in_frame = 1'b0;
  bit          prev_bck = 1'b0;
  bit          fs_seen = 1'b0;
  bit          fall_seen = 1'b0;
  bit          stream_on = 1'b0;
  logic [47:0] q[$];
  logic [47:0] cur = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected serial bit for frame slot s (0..63) of pair {left, right}.
  function automatic logic exp_bit(input logic [47:0] pair, input int s);
    logic [23:0] w;
    int p;
    w = (s >= 32) ? pair[23:0] : pair[47:24];
    p = s % 32;
    if (p >= 1 && p <= 24) return w[24-p];
    return 1'b0;
  endfunction

  task automatic new_pair();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = $urandom;
    in_left  = a[23:0];
    in_right = b[23:0];
  endtask

  // One clock: advance, then compare the DUT against the frame-level model.
  task automatic tick();
    logic acc;
    logic en_pre;
    logic fall;
    acc    = in_valid && in_ready;
    en_pre = enable;
    @(posedge clk);
    #1;
    cyc++;
    fall      = prev_bck && !dac_bck;
    prev_bck  = dac_bck;
    fs_seen   = frame_start;
    fall_seen = fall;
    if (frame_start) begin
      check("frame_start_on_bck_fall", 64'(fall), 64'(1));
      if (in_frame) begin
        check("frame_length", 64'(slot), 64'(63));
        check("bck_period_at_load", 64'(cyc - last_fall), 64'(2*BCK_DIV));
      end
      check("underrun_at_load", 64'(underrun), 64'(q.size() == 0));
      if (q.size() == 0) begin
        cur = '0;
        exp_urun++;
      end else begin
        cur = q.pop_front();
      end
      check("in_ready_after_load", 64'(in_ready), 64'(!acc));
      in_frame  = 1'b1;
      slot      = 0;
      last_fall = cyc;
      check("slot0_adata", 64'(dac_adata), 64'(0));
      check("slot0_lrck", 64'(dac_lrck), 64'(0));
    end else begin
      check("underrun_outside_load", 64'(underrun), 64'(0));
      if (fall && in_frame) begin
        check("bck_period", 64'(cyc - last_fall), 64'(2*BCK_DIV));
        last_fall = cyc;
        if (slot == 63) begin
          check("stop_only_when_disabled", 64'(en_pre), 64'(0));
          check("stop_lrck", 64'(dac_lrck), 64'(0));
          check("stop_adata", 64'(dac_adata), 64'(0));
          in_frame = 1'b0;
        end else begin
          slot++;
          check($sformatf("adata_slot%0d", slot), 64'(dac_adata), 64'(exp_bit(cur, slot)));
          check($sformatf("lrck_slot%0d", slot), 64'(dac_lrck), 64'(slot >= 32));
        end
      end
    end
    if (acc) begin
      q.push_back({in_left, in_right});
      check("in_ready_after_capture", 64'(in_ready), 64'(0));
      if (stream_on) new_pair();
      else in_valid = 1'b0;
    end
  endtask

  task automatic wait_frame_starts(input int n);
    int seen;
    seen = 0;
    for (int c = 0; c < n*400 && seen < n; c++) begin
      tick();
      if (fs_seen) seen++;
    end
    check("frame_start_timeout", 64'(seen), 64'(n));
  endtask

  task automatic wait_slot(input int s);
    bit found;
    found = 1'b0;
    for (int c = 0; c < 600 && !found; c++) begin
      tick();
      if (fall_seen && in_frame && slot == s) found = 1'b1;
    end
    check($sformatf("reach_slot%0d", s), 64'(found), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    repeat (3) tick();
    check("reset_bck", 64'(dac_bck), 64'(0));
    check("reset_lrck", 64'(dac_lrck), 64'(0));
    check("reset_adata", 64'(dac_adata), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_frame_start", 64'(frame_start), 64'(0));
`ifdef DAC_I2S_UNDERRUN_CNT_EN
    check("reset_underrun_cnt", 64'(underrun_cnt), 64'(0));
`endif
    rst_n = 1'b1;
    repeat (2) tick();

    // Preloaded pair, then one frame with no fresh data.
    in_left  = 24'hA5A5A5;
    in_right = 24'h5A5A5A;
    in_valid = 1'b1;
    tick();
    repeat (5) tick();
    check("idle_bck_while_disabled", 64'(dac_bck), 64'(0));
    enable = 1'b1;
    wait_frame_starts(2);

    // Continuous streaming of random pairs.
    stream_on = 1'b1;
    in_valid  = 1'b1;
    new_pair();
    wait_frame_starts(4);
    stream_on = 1'b0;
    wait_frame_starts(1);

    // Offer a pair exactly on the frame-load clock with the holding register empty.
    wait_slot(63);
    repeat (2*BCK_DIV - 1) tick();
    in_valid = 1'b1;
    new_pair();
    tick();
    check("valid_on_load_frame_start", 64'(fs_seen), 64'(1));
    check("valid_on_load_underrun", 64'(underrun), 64'(1));
    wait_frame_starts(1);

    // Drop enable mid-frame with a pair held; it must survive into the next run.
    wait_slot(10);
    enable   = 1'b0;
    in_valid = 1'b1;
    new_pair();
    tick();
    for (int c = 0; c < 400 && in_frame; c++) tick();
    check("idle_reached", 64'(in_frame), 64'(0));
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_bck", 64'(dac_bck), 64'(0));
      check("idle_frame_start", 64'(frame_start), 64'(0));
    end
    check("idle_lrck", 64'(dac_lrck), 64'(0));
    check("idle_adata", 64'(dac_adata), 64'(0));
    check("idle_hold_kept", 64'(in_ready), 64'(0));
    enable = 1'b1;
    wait_frame_starts(2);

    // Reset in the middle of a frame with a pair held.
    in_valid = 1'b1;
    new_pair();
    tick();
    wait_slot(40);
`ifdef DAC_I2S_UNDERRUN_CNT_EN
    check("underrun_cnt_total", 64'(underrun_cnt), 64'(exp_urun));
`endif
    rst_n = 1'b0;
    #2;
    check("async_reset_bck", 64'(dac_bck), 64'(0));
    check("async_reset_lrck", 64'(dac_lrck), 64'(0));
    check("async_reset_adata", 64'(dac_adata), 64'(0));
    check("async_reset_in_ready", 64'(in_ready), 64'(1));
    check("async_reset_underrun", 64'(underrun), 64'(0));
    check("async_reset_frame_start", 64'(frame_start), 64'(0));
    q.delete();
    in_frame = 1'b0;
    prev_bck = 1'b0;
    exp_urun = 0;
    tick();
    rst_n = 1'b1;
    wait_frame_starts(1);
    check("post_reset_underrun", 64'(underrun), 64'(1));
    tick();
`ifdef DAC_I2S_UNDERRUN_CNT_EN
    check("post_reset_underrun_cnt", 64'(underrun_cnt), 64'(1));
`endif
    enable = 1'b0;
    for (int c = 0; c < 400 && in_frame; c++) tick();
    check("final_idle", 64'(in_frame), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
